branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch prediction unit for the five-stage pipelined RV32I core. It replaces the fixed-size BHT/BTB pair with one direct-mapped, tagged table of configurable depth. Each entry holds a 2-bit saturating counter and an entry type, and a return-address stack (RAS) predicts JALR returns. The unit sits beside the IF stage: IF lookup is combinational, and updates are driven by the resolved branch/jump in EX. It also keeps branch and mispredict performance counters.

## Interface
- PC_WIDTH, 32, instruction address width
- ENTRIES, 64, table entries; power of two, ≥2; IDX_W = $clog2(ENTRIES)
- TAG_WIDTH, 8, tag bits; TAG_WIDTH+IDX_W+2 ≤ PC_WIDTH
- RAS_DEPTH, 4, return-stack entries; power of two, ≥2
- aclk  in  1  clock, all state on rising edge
- aresetn  in  1  reset; synchronous, active-low
- if_pc  in  PC_WIDTH  fetch PC
- pred_taken  out  1  redirect fetch to pred_target
- pred_target  out  PC_WIDTH  predicted target; 0 when pred_taken=0
- ex_valid  in  1  EX holds a real (non-flushed) instruction
- ex_pc  in  PC_WIDTH  PC of EX instruction
- ex_is_branch  in  1  conditional branch
- ex_is_jump  in  1  JAL/JALR
- ex_is_call  in  1  jump with rd ∈ {x1,x5}
- ex_is_ret  in  1  JALR with rs1 ∈ {x1,x5}, rd ∉ {x1,x5} or rd≠rs1
- ex_taken  in  1  resolved direction; ignored unless ex_is_branch
- ex_target  in  PC_WIDTH  resolved target
- ex_mispredict  in  1  direction or target mispredicted
- perf_branches  out  32  count of resolved branches and jumps
- perf_mispredicts  out  32  count of mispredicts

## Operation
- Index = pc[IDX_W+1:2]. Tag = pc[IDX_W+TAG_WIDTH+1:IDX_W+2].
- Entry fields: valid, tag, type (BR=0, JMP=1, RET=2), ctr[1:0], target.
- Lookup: hit = valid && tag match.
  - BR: pred_taken = ctr[1]; target from the entry.
  - JMP: pred_taken = 1; target from the entry.
  - RET: pred_taken = (ras_count≠0); target = RAS top.
  - Miss: pred_taken = 0.
- Update when ex_valid, by priority:
  1. ex_is_ret: write entry with type=RET and ctr=11.
  2. ex_is_jump: write entry with type=JMP, ctr=11, target=ex_target.
  3. ex_is_branch, on a hit with type BR:
     - ctr saturating +1 if taken, −1 if not.
     - target ← ex_target if taken.
  4. ex_is_branch, on a miss or a type≠BR hit:
     - taken: allocate with type=BR, ctr=10, target=ex_target.
     - not taken: leave the entry unchanged.
- Every write sets valid and tag.
- RAS is updated non-speculatively at EX, only when ex_valid && ex_is_jump:
  - Call: push ex_pc+4 (mod 2^PC_WIDTH).
  - Ret: pop.
  - Call and ret together: replace top with ex_pc+4; count unchanged, or 1 if it was 0.
  - Push when full: circular overwrite of the oldest entry; count saturates at RAS_DEPTH.
  - Pop when empty: no change.
- Perf counters (wrap at 2^32):
  - perf_branches +1 when ex_valid && (ex_is_branch || ex_is_jump).
  - perf_mispredicts +1 when ex_valid && ex_mispredict.
- Reset values:
  - All entries: valid=0, ctr=01, tag and target 0.
  - RAS pointer and count 0.
  - Perf counters 0.
  - Hence pred_taken=0 and pred_target=0.

## Timing
- Lookup is combinational and valid in the same cycle as if_pc. No stall path.
- Update is visible to lookups from the cycle after the EX edge.
- Same-cycle lookup and update of one index: the lookup sees the old contents (no bypass).
- Reset asserted mid-operation: all state clears at that edge. EX inputs in that cycle are discarded.
- ex_valid=0: no state change regardless of the other EX inputs.

## Structure
- Shared package (bp_pkg):
  - Entry-type enum (BP_BR, BP_JMP, BP_RET).
  - Counter constants CTR_WNT=01, CTR_WT=10.
  - Entry struct typedef.
- One sub-module: bp_ras (circular stack with push, pop, replace, top and count), instantiated once.
- Table storage is flops, not BRAM, because lookup is asynchronous.

## Test plan
- Reset, then if_pc=0x100 → pred_taken=0 and pred_target=0. perf counters are 0.
- Branch at 0x100, taken to 0x80 → next cycle pred_taken=1, target=0x80 (ctr=10). Then two not-taken resolves → pred_taken=0 (ctr=00). Three taken → ctr=11.
- Aliasing with ENTRIES=64: JAL at 0x100 with target 0x200, then lookup 0x4100 (same index, different tag) → miss, pred_taken=0.
- Call at 0x40 (→0x300), then ret JALR at 0x310 resolved; next lookup 0x310 → pred_taken=1, target=0x44. Pop empties the RAS → next lookup 0x310 gives pred_taken=0.
- RAS_DEPTH=4, five calls from 0x10,0x20,0x30,0x40,0x50, then five rets → targets 0x54,0x44,0x34,0x24, then count=0 → not taken.
- Same-cycle update and lookup of 0x100, plus reset mid-stream → lookup shows pre-update data. After reset all entries miss and counters read 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: entry type, counter encodings, entry control fields.
package bp_pkg;

  typedef enum logic [1:0] {
    BP_BR  = 2'd0,
    BP_JMP = 2'd1,
    BP_RET = 2'd2
  } bp_type_e;

  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Width-independent part of a table entry; tag/target widths live in the top.
  typedef struct packed {
    logic       valid;
    bp_type_e   typ;
    logic [1:0] ctr;
  } bp_ctl_t;

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'd1;
    else    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack; push/pop/replace resolved at EX, top and count combinational.
module bp_ras #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] stack [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;

  assign ptr_inc = ptr + PTR_W'(1);
  assign ptr_dec = ptr - PTR_W'(1);
  assign top     = stack[ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
    end else if (push && pop) begin
      // Call+return: replace top; an empty stack behaves like a push.
      if (count == '0) begin
        ptr            <= ptr_inc;
        stack[ptr_inc] <= din;
        count          <= CNT_W'(1);
      end else begin
        stack[ptr] <= din;
      end
    end else if (push) begin
      // When full, wrapping the pointer overwrites the oldest entry.
      ptr            <= ptr_inc;
      stack[ptr_inc] <= din;
      if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
    end else if (pop && count != '0) begin
      ptr   <= ptr_dec;
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped tagged predictor with 2-bit counters and a RAS; combinational IF lookup,
// EX-driven updates visible the following cycle, plus branch/mispredict counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_WIDTH  = 32,
  parameter int ENTRIES   = 64,
  parameter int TAG_WIDTH = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [PC_WIDTH-1:0] if_pc,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target,
  input  logic                ex_valid,
  input  logic [PC_WIDTH-1:0] ex_pc,
  input  logic                ex_is_branch,
  input  logic                ex_is_jump,
  input  logic                ex_is_call,
  input  logic                ex_is_ret,
  input  logic                ex_taken,
  input  logic [PC_WIDTH-1:0] ex_target,
  input  logic                ex_mispredict,
  output logic [31:0]         perf_branches,
  output logic [31:0]         perf_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  typedef struct packed {
    bp_ctl_t                ctl;
    logic [TAG_WIDTH-1:0]   tag;
    logic [PC_WIDTH-1:0]    target;
  } entry_t;

  localparam entry_t RST_ENTRY = '{
    ctl:    '{valid: 1'b0, typ: BP_BR, ctr: CTR_WNT},
    tag:    '0,
    target: '0
  };

  entry_t tbl [ENTRIES];

  logic [IDX_W-1:0]     lk_idx, ex_idx;
  logic [TAG_WIDTH-1:0] lk_tag, ex_tag;
  entry_t               lk_entry, ex_entry, wr_entry;
  logic                 lk_hit, ex_hit, wr_en;
  logic [PC_WIDTH-1:0]  ras_top;
  logic [CNT_W-1:0]     ras_count;

  assign lk_idx   = if_pc[IDX_W+1:2];
  assign lk_tag   = if_pc[IDX_W+TAG_WIDTH+1:IDX_W+2];
  assign ex_idx   = ex_pc[IDX_W+1:2];
  assign ex_tag   = ex_pc[IDX_W+TAG_WIDTH+1:IDX_W+2];
  assign lk_entry = tbl[lk_idx];
  assign ex_entry = tbl[ex_idx];
  assign lk_hit   = lk_entry.ctl.valid && (lk_entry.tag == lk_tag);
  assign ex_hit   = ex_entry.ctl.valid && (ex_entry.tag == ex_tag);

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = '0;
    if (lk_hit) begin
      case (lk_entry.ctl.typ)
        BP_BR: if (lk_entry.ctl.ctr[1]) begin
          pred_taken  = 1'b1;
          pred_target = lk_entry.target;
        end
        BP_JMP: begin
          pred_taken  = 1'b1;
          pred_target = lk_entry.target;
        end
        BP_RET: if (ras_count != '0) begin
          pred_taken  = 1'b1;
          pred_target = ras_top;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_en              = 1'b0;
    wr_entry           = ex_entry;
    wr_entry.ctl.valid = 1'b1;
    wr_entry.tag       = ex_tag;
    if (ex_valid) begin
      if (ex_is_ret) begin
        wr_en            = 1'b1;
        wr_entry.ctl.typ = BP_RET;
        wr_entry.ctl.ctr = CTR_ST;
      end else if (ex_is_jump) begin
        wr_en            = 1'b1;
        wr_entry.ctl.typ = BP_JMP;
        wr_entry.ctl.ctr = CTR_ST;
        wr_entry.target  = ex_target;
      end else if (ex_is_branch) begin
        if (ex_hit && ex_entry.ctl.typ == BP_BR) begin
          wr_en            = 1'b1;
          wr_entry.ctl.ctr = ctr_step(ex_entry.ctl.ctr, ex_taken);
          if (ex_taken) wr_entry.target = ex_target;
        end else if (ex_taken) begin
          // Not-taken branches never allocate, so they cannot evict useful entries.
          wr_en            = 1'b1;
          wr_entry.ctl.typ = BP_BR;
          wr_entry.ctl.ctr = CTR_WT;
          wr_entry.target  = ex_target;
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= RST_ENTRY;
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (wr_en) tbl[ex_idx] <= wr_entry;
      if (ex_valid && (ex_is_branch || ex_is_jump)) perf_branches <= perf_branches + 32'd1;
      if (ex_valid && ex_mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
    end
  end

  bp_ras #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_ras (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (ex_valid && ex_is_jump && ex_is_call),
    .pop   (ex_valid && ex_is_jump && ex_is_ret),
    .din   (ex_pc + PC_WIDTH'(4)),
    .top   (ras_top),
    .count (ras_count)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: counters, aliasing, RAS, timing and reset behaviour.
module tb_branch_predictor;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_is_jump, ex_is_call, ex_is_ret, ex_taken, ex_mispredict;
  logic [31:0] ex_pc, ex_target;
  logic [31:0] perf_branches, perf_mispredicts;

  int checks = 0;
  int passed = 0;
  int exp_br = 0;
  int exp_mp = 0;

  always #5 aclk = ~aclk;

  branch_predictor #(
    .PC_WIDTH(32), .ENTRIES(64), .TAG_WIDTH(8), .RAS_DEPTH(4)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_is_branch     (ex_is_branch),
    .ex_is_jump       (ex_is_jump),
    .ex_is_call       (ex_is_call),
    .ex_is_ret        (ex_is_ret),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_mispredict    (ex_mispredict),
    .perf_branches    (perf_branches),
    .perf_mispredicts (perf_mispredicts)
  );

  task automatic ex_idle();
    ex_valid = 0; ex_pc = '0; ex_is_branch = 0; ex_is_jump = 0; ex_is_call = 0;
    ex_is_ret = 0; ex_taken = 0; ex_target = '0; ex_mispredict = 0;
  endtask

  task automatic look(input logic [31:0] pc);
    if_pc = pc;
    #1;
  endtask

  // One resolved EX instruction, applied for exactly one rising edge.
  task automatic ex_op(input logic [31:0] pc, input logic br, input logic jmp, input logic call,
                       input logic ret, input logic tk, input logic [31:0] tgt, input logic mp);
    @(negedge aclk);
    ex_valid = 1; ex_pc = pc; ex_is_branch = br; ex_is_jump = jmp; ex_is_call = call;
    ex_is_ret = ret; ex_taken = tk; ex_target = tgt; ex_mispredict = mp;
    @(posedge aclk);
    #1;
    ex_idle();
    if (br || jmp) exp_br++;
    if (mp) exp_mp++;
  endtask

  task automatic test_reset();
    aresetn = 0;
    ex_idle();
    if_pc = '0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1;
    look(32'h100);
    checks++; if (pred_taken !== 1'b0) $display("FAIL reset_taken got=%b exp=0", pred_taken); else passed++;
    checks++; if (pred_target !== 32'h0) $display("FAIL reset_target got=%h exp=0", pred_target); else passed++;
    checks++; if (perf_branches !== 32'd0 || perf_mispredicts !== 32'd0)
      $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_branches, perf_mispredicts); else passed++;
  endtask

  task automatic test_counter();
    logic exp_tk [7];
    exp_tk = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    // taken: alloc 10; nt ->01; nt ->00; t ->01; t ->10; t ->11; then nt ->10
    ex_op(32'h100, 1, 0, 0, 0, 1, 32'h80, 1);
    look(32'h100);
    checks++; if (pred_taken !== exp_tk[0] || pred_target !== 32'h80)
      $display("FAIL ctr_alloc got=%b/%h exp=1/00000080", pred_taken, pred_target); else passed++;
    for (int i = 1; i < 7; i++) begin
      ex_op(32'h100, 1, 0, 0, 0, (i >= 3 && i <= 5), 32'h80, (i == 1));
      look(32'h100);
      checks++; if (pred_taken !== exp_tk[i])
        $display("FAIL ctr_step%0d got=%b exp=%b", i, pred_taken, exp_tk[i]); else passed++;
    end
    checks++; if (pred_target !== 32'h80) $display("FAIL ctr_target got=%h exp=00000080", pred_target); else passed++;
    checks++; if (perf_branches !== 32'd7 || perf_mispredicts !== 32'd2)
      $display("FAIL ctr_perf got=%0d/%0d exp=7/2", perf_branches, perf_mispredicts); else passed++;
  endtask

  task automatic test_alias();
    ex_op(32'h100, 0, 1, 0, 0, 0, 32'h200, 1);
    look(32'h100);
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h200)
      $display("FAIL alias_jmp got=%b/%h exp=1/00000200", pred_taken, pred_target); else passed++;
    look(32'h4100);
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h0)
      $display("FAIL alias_miss got=%b/%h exp=0/0", pred_taken, pred_target); else passed++;
  endtask

  task automatic test_ras_basic();
    ex_op(32'h310, 0, 1, 0, 1, 0, 32'h0, 1);   // ret with empty RAS: entry only
    look(32'h310);
    checks++; if (pred_taken !== 1'b0) $display("FAIL ras_empty got=%b exp=0", pred_taken); else passed++;
    ex_op(32'h40, 0, 1, 1, 0, 0, 32'h300, 0);
    look(32'h310);
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h44)
      $display("FAIL ras_ret got=%b/%h exp=1/00000044", pred_taken, pred_target); else passed++;
    look(32'h40);
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h300)
      $display("FAIL ras_call_entry got=%b/%h exp=1/00000300", pred_taken, pred_target); else passed++;
    ex_op(32'h310, 0, 1, 0, 1, 0, 32'h44, 0);
    look(32'h310);
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h0)
      $display("FAIL ras_popped got=%b/%h exp=0/0", pred_taken, pred_target); else passed++;
  endtask

  task automatic test_ras_deep();
    logic [31:0] exp_tgt [5];
    exp_tgt = '{32'h54, 32'h44, 32'h34, 32'h24, 32'h0};
    ex_op(32'h31C, 0, 1, 0, 1, 0, 32'h0, 0);
    for (int i = 1; i <= 5; i++) ex_op(32'h10 * i, 0, 1, 1, 0, 0, 32'h300, 0);
    for (int i = 0; i < 5; i++) begin
      look(32'h31C);
      checks++; if (pred_taken !== (i < 4) || pred_target !== exp_tgt[i])
        $display("FAIL ras_deep%0d got=%b/%h exp=%b/%h", i, pred_taken, pred_target, (i < 4), exp_tgt[i]);
      else passed++;
      ex_op(32'h31C, 0, 1, 0, 1, 0, 32'h0, 0);
    end
    look(32'h31C);
    checks++; if (pred_taken !== 1'b0) $display("FAIL ras_underflow got=%b exp=0", pred_taken); else passed++;
  endtask

  task automatic test_call_ret();
    ex_op(32'h60, 0, 1, 1, 1, 0, 32'h400, 0);  // empty: acts as push of 0x64
    look(32'h31C);
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h64)
      $display("FAIL callret_empty got=%b/%h exp=1/00000064", pred_taken, pred_target); else passed++;
    ex_op(32'h70, 0, 1, 1, 1, 0, 32'h400, 0);  // replace top
    look(32'h31C);
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h74)
      $display("FAIL callret_replace got=%b/%h exp=1/00000074", pred_taken, pred_target); else passed++;
    ex_op(32'h31C, 0, 1, 0, 1, 0, 32'h0, 0);
    look(32'h31C);
    checks++; if (pred_taken !== 1'b0) $display("FAIL callret_count got=%b exp=0", pred_taken); else passed++;
    look(32'h60);
    checks++; if (pred_taken !== 1'b0) $display("FAIL callret_type got=%b exp=0", pred_taken); else passed++;
  endtask

  task automatic test_ex_invalid();
    @(negedge aclk);
    ex_valid = 0; ex_pc = 32'h100; ex_is_branch = 1; ex_is_jump = 1; ex_is_call = 1;
    ex_is_ret = 1; ex_taken = 1; ex_target = 32'h999; ex_mispredict = 1;
    @(posedge aclk);
    #1;
    ex_idle();
    look(32'h100);
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h200)
      $display("FAIL invalid_entry got=%b/%h exp=1/00000200", pred_taken, pred_target); else passed++;
    checks++; if (perf_branches !== 32'(exp_br) || perf_mispredicts !== 32'(exp_mp))
      $display("FAIL invalid_perf got=%0d/%0d exp=%0d/%0d", perf_branches, perf_mispredicts, exp_br, exp_mp);
    else passed++;
  endtask

  task automatic test_same_cycle();
    @(negedge aclk);
    if_pc = 32'h100;
    ex_valid = 1; ex_pc = 32'h100; ex_is_jump = 1; ex_target = 32'h300;
    #1;
    checks++; if (pred_target !== 32'h200)
      $display("FAIL same_cycle_old got=%h exp=00000200", pred_target); else passed++;
    @(posedge aclk);
    #1;
    ex_idle();
    exp_br++;
    checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h300)
      $display("FAIL same_cycle_new got=%b/%h exp=1/00000300", pred_taken, pred_target); else passed++;
  endtask

  task automatic test_reset_mid();
    @(negedge aclk);
    aresetn = 0;
    ex_valid = 1; ex_pc = 32'h180; ex_is_jump = 1; ex_target = 32'h500; ex_mispredict = 1;
    @(posedge aclk);
    #1;
    ex_idle();
    aresetn = 1;
    exp_br = 0; exp_mp = 0;
    look(32'h100);
    checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h0)
      $display("FAIL rst_mid_100 got=%b/%h exp=0/0", pred_taken, pred_target); else passed++;
    look(32'h180);
    checks++; if (pred_taken !== 1'b0) $display("FAIL rst_mid_discard got=%b exp=0", pred_taken); else passed++;
    checks++; if (perf_branches !== 32'(exp_br) || perf_mispredicts !== 32'(exp_mp))
      $display("FAIL rst_mid_perf got=%0d/%0d exp=0/0", perf_branches, perf_mispredicts); else passed++;
    ex_op(32'h31C, 0, 1, 0, 1, 0, 32'h0, 0);
    look(32'h31C);
    checks++; if (pred_taken !== 1'b0) $display("FAIL rst_mid_ras got=%b exp=0", pred_taken); else passed++;
    checks++; if (perf_branches !== 32'd1) $display("FAIL rst_mid_count got=%0d exp=1", perf_branches); else passed++;
  endtask

  initial begin
    test_reset();
    test_counter();
    test_alias();
    test_ras_basic();
    test_ras_deep();
    test_call_ret();
    test_ex_invalid();
    test_same_cycle();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
